seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider with valid/ready
// handshakes on both sides. One operation is in flight at a time.
// Optional build macro DIV_SIGNED_EN: operands and results are two's
// complement. The core divides magnitudes, truncating toward zero, and the
// sign fix-up is applied when the result registers are loaded.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one shift/trial-subtract iteration per clock
// DONE  | result presented, waiting for out_ready
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [VW:0]   prem;
  logic [DW-1:0] qreg;
  logic [VW-1:0] dvs;

  logic [VW:0]   shifted, diff, prem_nx;
  logic [DW-1:0] qreg_nx;
  logic          ge;
  logic [DW-1:0] a_mag, q_res;
  logic [VW-1:0] b_mag, r_res;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // One restoring iteration; the extra partial-remainder bit holds the
  // borrow of the trial subtraction and never reaches an output.
  always_comb begin
    shifted = {prem[VW-1:0], qreg[DW-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = ~diff[VW];
    prem_nx = ge ? diff : shifted;
    qreg_nx = {qreg[DW-2:0], ge};
  end

  // Operand magnitudes going in, sign-corrected results coming out
  always_comb begin
`ifdef DIV_SIGNED_EN
    a_mag = dividend[DW-1] ? (DW'(0) - dividend) : dividend;
    b_mag = divisor[VW-1]  ? (VW'(0) - divisor)  : divisor;
    q_res = neg_q ? (DW'(0) - qreg_nx) : qreg_nx;
    r_res = neg_r ? (VW'(0) - prem_nx[VW-1:0]) : prem_nx[VW-1:0];
`else
    a_mag = dividend;
    b_mag = divisor;
    q_res = qreg_nx;
    r_res = prem_nx[VW-1:0];
`endif
  end

  // Datapath: operand capture, iteration, result load on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prem        <= '0;
      qreg        <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              cnt  <= CW'(DW - 1);
              prem <= '0;
              qreg <= a_mag;
              dvs  <= b_mag;
`ifdef DIV_SIGNED_EN
              neg_q <= dividend[DW-1] ^ divisor[VW-1];
              neg_r <= dividend[DW-1];
`endif
            end
          end
        end
        CALC: begin
          prem <= prem_nx;
          qreg <= qreg_nx;
          if (cnt == '0) begin
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q;
  logic [VW-1:0] exp_r;
  logic          exp_z;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer division with the zero-divisor convention.
  task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int sa, sb, q, r;
`ifdef DIV_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    if (sb == 0) begin
      exp_q = '1;
      exp_r = '0;
      exp_z = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      exp_q = DW'(q);
      exp_r = VW'(r);
      exp_z = 1'b0;
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after E0.
  task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    model(a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = VW'($urandom);
  endtask

  // Edges after the accepting edge until out_valid: DW normally, 0 for a
  // zero divisor (the accepting edge itself loads the result).
  task automatic wait_result(input string tag, input int exp_lat);
    int cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
    chk({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_z));
  endtask

  task automatic release_result(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("released_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b, input int hold);
    start_op(a, b);
    wait_result(tag, (b == '0) ? 0 : DW);
    release_result(hold);
  endtask

  initial begin
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("d200_7", 8'hC8, 4'h7, 0);
`ifndef DIV_SIGNED_EN
    chk("d200_7_const_q", 32'(exp_q), 32'h1C);
`endif
    run_op("d255_1", 8'hFF, 4'h1, 1);
    run_op("dE1_F", 8'hE1, 4'hF, 0);
    run_op("d55_0", 8'h55, 4'h0, 2);

    // Backpressure: result held while new operands wait on the input.
    start_op(8'h64, 4'h3);
    wait_result("bp", DW);
    dividend = 8'hAB;
    divisor  = 4'h5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_quotient_stable", 32'(quotient), 32'(exp_q));
      chk("bp_remainder_stable", 32'(remainder), 32'(exp_r));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_back_idle_valid", 32'(out_valid), 32'd0);
    chk("bp_back_idle_ready", 32'(in_ready), 32'd1);
    model(8'hAB, 4'h5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", 32'(in_ready), 32'd0);
    wait_result("bp_next", DW);
    release_result(0);

    // Reset in the middle of an iteration sequence.
    start_op(8'hC8, 4'h7);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("d100_3", 8'h64, 4'h3, 0);
`ifndef DIV_SIGNED_EN
    chk("d100_3_const_q", 32'(exp_q), 32'h21);
    chk("d100_3_const_r", 32'(exp_r), 32'h1);
`endif

`ifdef DIV_SIGNED_EN
    run_op("s9C_7", 8'h9C, 4'h7, 0);
    chk("s9C_7_const_q", 32'(exp_q), 32'hF2);
    chk("s9C_7_const_r", 32'(exp_r), 32'hE);
    run_op("s80_F", 8'h80, 4'hF, 0);
    chk("s80_F_const_q", 32'(exp_q), 32'h80);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = DW'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
      run_op("rand", ra, rb, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
